rr_arbiter_4: RTL and testbench
===============================

Name: rr_arbiter_4

Overview:
- Round-robin arbiter that shares one downstream resource (e.g. a shared encoder/datapath slot) among 4 requesters.
- Produces a one-hot grant, a 2-bit encoded grant index and a grant-valid flag. The index is valid only while a grant is active, so it never carries an invalid code.
- Grant is held until the owner releases it. Fairness comes from a rotating priority pointer.

Parameters:
- NREQ, 4, number of requesters. Fixed at 4; the parameter exists for package consistency only.
- HOLD_MAX, 16, maximum grant length in cycles. Used only when ARB_TIMEOUT_EN is defined.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req  input  4  request vector; bit i = requester i
- done  input  1  release pulse from the current grantee
- gnt  output  4  one-hot grant; all zero when idle
- gnt_idx  output  2  binary index of the granted requester; 0 when idle
- gnt_vld  output  1  high while any grant is active
- timeout  output  1  one-cycle pulse on forced release; tied 0 without the macro

Behaviour:
- Single clock, one-cycle registered latency. Arbitration decisions are combinational; all outputs are registers.
- Reset (async, rst_n=0):
  - gnt=0, gnt_idx=0, gnt_vld=0, timeout=0.
  - state=IDLE, last_idx=3, so requester 0 has top priority after reset.
  - Reset mid-grant drops the grant immediately, without waiting for a clock edge.
- States:
  - IDLE: no grant.
    - If req!=0, pick the winner, load gnt/gnt_idx, set gnt_vld=1, go to BUSY. The grant is visible on the next cycle.
    - If req=0, stay in IDLE.
  - BUSY: grant held.
    - A release occurs when done=1, or when req[gnt_idx]=0. Both together count as one release.
    - On release with other requests pending: re-arbitrate the same cycle, so the new grant appears the next cycle with no idle gap. Stay in BUSY.
    - On release with no request left: go to IDLE, and gnt/gnt_vld drop the next cycle.
- Winner selection:
  - Search from (last_idx+1) mod 4 upward, wrapping 3->0. The first set req bit wins.
  - The releasing requester is searched last, so it re-wins only if it is the sole requester.
  - last_idx updates to the winner index on every new grant.
- done while IDLE is ignored. Requests that change during BUSY do not pre-empt the current grantee.
- Invariants, checked every cycle:
  - gnt is one-hot or zero.
  - gnt_vld == |gnt.
  - gnt == (1<<gnt_idx) whenever gnt_vld=1.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - A hold counter of width $clog2(HOLD_MAX+1) clears on each new grant and increments every BUSY cycle.
  - When it reaches HOLD_MAX-1 with no release that cycle, the arbiter forces a release and pulses timeout=1 for one cycle, aligned with the grant change.
  - The pointer then advances exactly as for a normal release.
  - A normal release on the same cycle as the limit takes precedence: no timeout pulse.
- Undefined: no counter; timeout is constant 0; a grant may be held indefinitely.

Decomposition:
- Package arb_pkg:
  - NREQ=4 and IDX_W=2.
  - State typedef: IDLE=1'b0, BUSY=1'b1.
  - Default HOLD_MAX.
- Sub-module rr_pick_4 (combinational): inputs req[3:0] and last_idx[1:0]; outputs win_idx[1:0] and win_vld. Rotating priority encoder.
- Top level contains the FSM, registers and the optional timeout counter.

Test Plan:
- Reset release with req=4'b1111: the first grant next cycle is gnt=0001, idx=0, vld=1. Then pulse done every 2 cycles: grant order is 0,1,2,3,0, with no idle cycle between grants.
- Sparse requests, req=4'b1010 from IDLE after reset: grants go 1 -> 3 -> 1 on successive done pulses. Then req=0 on release: gnt=0, vld=0, idx=0 the next cycle.
- Sole requester, req=4'b0100: each done re-grants idx=2 the next cycle. Setting req[0] while idx 2 is held does not pre-empt; after done, idx=0 is granted.
- Requester drops req[1] without done while granted: release occurs, and the next pending requester (e.g. 3 when req=1000) is granted the next cycle.
- Assert rst_n=0 asynchronously while BUSY, between clock edges: outputs go to 0 immediately. After release, the pointer restarts at requester 0.
- With ARB_TIMEOUT_EN, HOLD_MAX=4, req=0011 and no done: a forced release after 4 BUSY cycles, timeout=1 for one cycle, then idx 0 -> 1. Same stimulus without the macro: idx 0 is held indefinitely and timeout stays 0.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and constants for the 4-way round-robin arbiter.
package arb_pkg;

  localparam int unsigned NREQ         = 4;
  localparam int unsigned IDX_W        = 2;
  localparam int unsigned HOLD_MAX_DEF = 16;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  function automatic logic [NREQ-1:0] idx2onehot(input logic [IDX_W-1:0] idx);
    idx2onehot      = '0;
    idx2onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/rr_pick_4.sv
// Rotating priority encoder: first set request at or after (last_idx+1) mod 4.
module rr_pick_4
  import arb_pkg::*;
(
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] last_idx,
  output logic [IDX_W-1:0] win_idx,
  output logic             win_vld
);

  logic [IDX_W-1:0] cand;

  // Walk from farthest to nearest so the nearest set bit is the final assignment.
  always_comb begin
    win_idx = '0;
    win_vld = 1'b0;
    cand    = '0;
    for (int unsigned i = NREQ; i >= 1; i--) begin
      cand = last_idx + IDX_W'(i);
      if (req[cand]) begin
        win_idx = cand;
        win_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter_4.sv
// Round-robin arbiter, 4 requesters, grant held until release.
// Define ARB_TIMEOUT_EN to force release after HOLD_MAX busy cycles.
module rr_arbiter_4 #(
  parameter int unsigned NREQ     = arb_pkg::NREQ,
  parameter int unsigned HOLD_MAX = arb_pkg::HOLD_MAX_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NREQ-1:0]           req,
  input  logic                      done,
  output logic [NREQ-1:0]           gnt,
  output logic [arb_pkg::IDX_W-1:0] gnt_idx,
  output logic                      gnt_vld,
  output logic                      timeout
);

  import arb_pkg::*;

  arb_state_e       state_q, state_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic             vld_q, vld_d;
  logic             to_q, to_d;

  logic [IDX_W-1:0] win_idx;
  logic             win_vld;
  logic             norm_rel;
  logic             force_rel;
  logic             new_grant;

  rr_pick_4 u_pick (
    .req      (req),
    .last_idx (last_q),
    .win_idx  (win_idx),
    .win_vld  (win_vld)
  );

  assign norm_rel = done | ~req[idx_q];

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    idx_d     = idx_q;
    last_d    = last_q;
    vld_d     = vld_q;
    to_d      = 1'b0;
    new_grant = 1'b0;
    case (state_q)
      IDLE: new_grant = win_vld;
      BUSY: begin
        if (norm_rel || force_rel) begin
          to_d = ~norm_rel;
          if (win_vld) begin
            new_grant = 1'b1;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
            idx_d   = '0;
            vld_d   = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (new_grant) begin
      state_d = BUSY;
      gnt_d   = idx2onehot(win_idx);
      idx_d   = win_idx;
      last_d  = win_idx;
      vld_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      idx_q   <= '0;
      last_q  <= IDX_W'(NREQ - 1);
      vld_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      vld_q   <= vld_d;
      to_q    <= to_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(HOLD_MAX + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign force_rel = (state_q == BUSY) && (cnt_q == CNT_W'(HOLD_MAX - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (new_grant)             cnt_d = '0;
    else if (state_q == BUSY)  cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`else
  logic unused_cfg;
  assign force_rel  = 1'b0;
  assign unused_cfg = ^{HOLD_MAX, new_grant};
`endif

  assign gnt     = gnt_q;
  assign gnt_idx = idx_q;
  assign gnt_vld = vld_q;
  assign timeout = to_q;

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Directed scoreboard bench for rr_arbiter_4 (HOLD_MAX overridden to 4).
module tb_rr_arbiter_4;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_vld;
  logic       timeout;

  typedef struct {
    logic [1:0] idx;
    logic       vld;
    logic       to;
    int         step;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   step_no = 0;

  rr_arbiter_4 #(.HOLD_MAX(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .done    (done),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld),
    .timeout (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, queue=%0d", q.size());
    $fatal(1, "watchdog");
  end

  // Monitor: invariants every cycle plus scoreboard pop.
  always @(negedge clk) begin
    exp_t       e;
    logic [3:0] eg;
    n_tests++;
    if (!($onehot0(gnt) && (gnt_vld == |gnt) && (!gnt_vld || gnt == (4'b0001 << gnt_idx)))) begin
      n_fail++;
      $display("FAIL invariant: got gnt=%b idx=%0d vld=%b", gnt, gnt_idx, gnt_vld);
    end
    if (q.size() > 0) begin
      e  = q.pop_front();
      eg = e.vld ? (4'b0001 << e.idx) : 4'b0000;
      n_tests++;
      if ({gnt, gnt_idx, gnt_vld, timeout} !== {eg, e.idx, e.vld, e.to}) begin
        n_fail++;
        $display("FAIL step%0d: got gnt=%b idx=%0d vld=%b to=%b, want gnt=%b idx=%0d vld=%b to=%b",
                 e.step, gnt, gnt_idx, gnt_vld, timeout, eg, e.idx, e.vld, e.to);
      end
    end
  end

  task automatic cyc(input logic [3:0] r, input logic d, input logic [1:0] ei,
                     input logic ev, input logic et);
    req  = r;
    done = d;
    @(posedge clk);
    q.push_back('{idx: ei, vld: ev, to: et, step: step_no});
    step_no++;
    #1;
  endtask

  task automatic check_zero(input string name);
    n_tests++;
    if ({gnt, gnt_idx, gnt_vld, timeout} !== 8'b0) begin
      n_fail++;
      $display("FAIL %s: got gnt=%b idx=%0d vld=%b to=%b, want all zero",
               name, gnt, gnt_idx, gnt_vld, timeout);
    end
  endtask

  // Asserted between edges after the monitor sample; released just after a posedge.
  task automatic do_reset(input string name);
    #6;
    rst_n = 1'b0;
    #1;
    check_zero(name);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 4'b0000;
    done  = 1'b0;
    @(posedge clk);
    #1;
    check_zero("reset_state");
    rst_n = 1'b1;

    // Full contention, done every second cycle: 0,1,2,3,0 with no gap.
    cyc(4'b1111, 1'b0, 2'd0, 1'b1, 1'b0);
    cyc(4'b1111, 1'b0, 2'd0, 1'b1, 1'b0);
    cyc(4'b1111, 1'b1, 2'd1, 1'b1, 1'b0);
    cyc(4'b1111, 1'b0, 2'd1, 1'b1, 1'b0);
    cyc(4'b1111, 1'b1, 2'd2, 1'b1, 1'b0);
    cyc(4'b1111, 1'b0, 2'd2, 1'b1, 1'b0);
    cyc(4'b1111, 1'b1, 2'd3, 1'b1, 1'b0);
    cyc(4'b1111, 1'b0, 2'd3, 1'b1, 1'b0);
    cyc(4'b1111, 1'b1, 2'd0, 1'b1, 1'b0);
    cyc(4'b0000, 1'b0, 2'd0, 1'b0, 1'b0);

    // Sparse requests from reset: 1 -> 3 -> 1, then idle; done while idle ignored.
    do_reset("reset_idle");
    cyc(4'b1010, 1'b0, 2'd1, 1'b1, 1'b0);
    cyc(4'b1010, 1'b1, 2'd3, 1'b1, 1'b0);
    cyc(4'b1010, 1'b1, 2'd1, 1'b1, 1'b0);
    cyc(4'b0000, 1'b0, 2'd0, 1'b0, 1'b0);
    cyc(4'b0000, 1'b1, 2'd0, 1'b0, 1'b0);

    // Sole requester re-wins; a new request does not pre-empt.
    cyc(4'b0100, 1'b0, 2'd2, 1'b1, 1'b0);
    cyc(4'b0100, 1'b1, 2'd2, 1'b1, 1'b0);
    cyc(4'b0100, 1'b1, 2'd2, 1'b1, 1'b0);
    cyc(4'b0101, 1'b0, 2'd2, 1'b1, 1'b0);
    cyc(4'b0101, 1'b1, 2'd0, 1'b1, 1'b0);

    // Grantee drops its request without done.
    cyc(4'b1010, 1'b1, 2'd1, 1'b1, 1'b0);
    cyc(4'b1000, 1'b0, 2'd3, 1'b1, 1'b0);
    cyc(4'b1000, 1'b0, 2'd3, 1'b1, 1'b0);

    // Async reset while busy, pointer restarts at 0.
    do_reset("reset_async_busy");
    cyc(4'b1111, 1'b0, 2'd0, 1'b1, 1'b0);
    cyc(4'b1111, 1'b1, 2'd1, 1'b1, 1'b0);

    do_reset("reset_before_hold");
    cyc(4'b0011, 1'b0, 2'd0, 1'b1, 1'b0);
`ifdef ARB_TIMEOUT_EN
    cyc(4'b0011, 1'b0, 2'd0, 1'b1, 1'b0);
    cyc(4'b0011, 1'b0, 2'd0, 1'b1, 1'b0);
    cyc(4'b0011, 1'b0, 2'd0, 1'b1, 1'b0);
    cyc(4'b0011, 1'b0, 2'd1, 1'b1, 1'b1);
    cyc(4'b0011, 1'b0, 2'd1, 1'b1, 1'b0);
    cyc(4'b0011, 1'b0, 2'd1, 1'b1, 1'b0);
    cyc(4'b0011, 1'b0, 2'd1, 1'b1, 1'b0);
    cyc(4'b0011, 1'b1, 2'd0, 1'b1, 1'b0);
    cyc(4'b0011, 1'b0, 2'd0, 1'b1, 1'b0);
`else
    for (int i = 0; i < 9; i++) cyc(4'b0011, 1'b0, 2'd0, 1'b1, 1'b0);
`endif

    @(negedge clk);
    #1;
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expectations, want 0", q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
